// File: rtl/keypad_pkg.sv
// Shared constants for the keypad front end: key codes, the default 4x3
// code map and the press-FSM state encoding.
package keypad_pkg;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  // Slice i is the code for key_raw[i]: 0..8 -> 1..9, 9 -> '*', 10 -> 0, 11 -> '#'
  localparam logic [47:0] KEYMAP_12 = {KEY_HASH, 4'd0, KEY_STAR, 4'd9, 4'd8, 4'd7,
                                       4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2,
    ST_LOCK   = 2'd3
  } press_state_e;

endpackage

// File: rtl/key_debounce.sv
// One key: 2-FF synchroniser followed by a stable-level debounce counter.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw_i,
  output logic db_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          db_q;
  logic [CW-1:0] cnt_q;

  // Synchronise, then flip db once the new level has held for DEBOUNCE_CYCLES samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      db_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], key_raw_i};
      if (sync_q[1] == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        db_q  <= sync_q[1];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/button_keypad_db.sv
// Keypad front end: per-key debounce, single-key press FSM with chord lockout
// and optional auto-repeat, and a small event FIFO with valid/ready output.
module button_keypad_db
  import keypad_pkg::*;
#(
  parameter int                         NUM_KEYS        = 12,
  parameter int                         CODE_W          = 4,
  parameter logic [NUM_KEYS*CODE_W-1:0] KEYMAP          = KEYMAP_12,
  parameter int                         DEBOUNCE_CYCLES = 250000,
  parameter bit                         REPEAT_EN       = 1'b0,
  parameter int                         REPEAT_DELAY    = 25000000,
  parameter int                         REPEAT_RATE     = 5000000,
  parameter int                         FIFO_DEPTH      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_raw,
  input  logic                key_ready,
  output logic                key_valid,
  output logic [CODE_W-1:0]   key_value,
  output logic                key_held,
  output logic                overflow
);

  localparam int IW      = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RCW     = $clog2(RPT_MAX + 1);
  localparam logic [RCW-1:0] DELAY_LAST = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] RATE_LAST  = RCW'(REPEAT_RATE - 1);

  logic [NUM_KEYS-1:0] db;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_raw_i (key_raw[gi]),
      .db_o      (db[gi])
    );
  end

  press_state_e        state_q, state_d;
  logic [IW-1:0]       key_idx_q, key_idx_d;
  logic [RCW-1:0]      rep_cnt_q, rep_cnt_d;
  logic                key_held_q;
  logic                seen, multi, emit;
  logic [IW-1:0]       hit_idx, emit_idx;
  logic [NUM_KEYS-1:0] others;
  logic [CODE_W-1:0]   emit_code;

  // Classify the debounced vector (none / exactly one / chord) and pick the next FSM step
  always_comb begin
    seen    = 1'b0;
    multi   = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (db[i]) begin
        if (seen) multi = 1'b1;
        seen    = 1'b1;
        hit_idx = IW'(i);
      end
    end
    others    = db & ~(NUM_KEYS'(1) << key_idx_q);
    state_d   = state_q;
    key_idx_d = key_idx_q;
    rep_cnt_d = rep_cnt_q;
    emit      = 1'b0;
    emit_idx  = key_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (multi) begin
          state_d = ST_LOCK;
        end else if (seen) begin
          emit      = 1'b1;
          emit_idx  = hit_idx;
          key_idx_d = hit_idx;
          rep_cnt_d = '0;
          state_d   = ST_HELD;
        end
      end
      ST_HELD, ST_REPEAT: begin
        if (others != '0) begin
          state_d = ST_LOCK;
        end else if (!db[key_idx_q]) begin
          state_d = ST_IDLE;
        end else if (REPEAT_EN) begin
          // Counter was cleared on the previous emission edge
          if (rep_cnt_q == ((state_q == ST_HELD) ? DELAY_LAST : RATE_LAST)) begin
            emit      = 1'b1;
            rep_cnt_d = '0;
            state_d   = ST_REPEAT;
          end else begin
            rep_cnt_d = rep_cnt_q + RCW'(1);
          end
        end
      end
      default: begin
        if (db == '0) state_d = ST_IDLE;
      end
    endcase
    emit_code = KEYMAP[int'(emit_idx)*CODE_W +: CODE_W];
  end

  // Press FSM registers; key_held is registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      key_idx_q  <= '0;
      rep_cnt_q  <= '0;
      key_held_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_idx_q  <= key_idx_d;
      rep_cnt_q  <= rep_cnt_d;
      key_held_q <= (state_d == ST_HELD) || (state_d == ST_REPEAT);
    end
  end

  logic [FIFO_DEPTH-1:0][CODE_W-1:0] mem_q;
  logic [AW:0]                       wr_ptr_q, rd_ptr_q;
  logic                              ovf_q;
  logic                              empty, full, rd_en, wr_en, drop;

  // Extra pointer MSB distinguishes full from empty; a read frees room for a same-cycle write
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    rd_en = !empty && key_ready;
    wr_en = emit && (!full || rd_en);
    drop  = emit && full && !rd_en;
  end

  // Event queue storage, pointers and the drop pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q[AW-1:0]] <= emit_code;
        wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
      end
      if (rd_en) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      ovf_q <= drop;
    end
  end

  assign key_valid = !empty;
  assign key_value = mem_q[rd_ptr_q[AW-1:0]];
  assign key_held  = key_held_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_button_keypad_db.sv
// Self-checking bench for button_keypad_db: table of single presses plus
// hand-written chord, glitch, repeat, overflow and reset sequences. Expected
// events (code, visible cycle) go into a queue when the stimulus is driven and
// are popped when the DUT hands an event over.
module tb_button_keypad_db;

  localparam int NK = 12;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] key_raw = '0;
  logic          key_ready = 1'b1;
  logic          key_valid;
  logic [CW-1:0] key_value;
  logic          key_held;
  logic          overflow;

  always #5 clk = ~clk;

  button_keypad_db #(
    .NUM_KEYS(NK), .CODE_W(CW), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b1),
    .REPEAT_DELAY(20), .REPEAT_RATE(8), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_raw(key_raw), .key_ready(key_ready),
    .key_valid(key_valid), .key_value(key_value), .key_held(key_held),
    .overflow(overflow)
  );

  typedef struct { int code; int cyc; } exp_t;
  typedef struct { int key;  int code; } vec_t;

  exp_t exp_q[$];
  vec_t vecs[12];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ov_cnt = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Called at each negedge: consume handshakes against the scoreboard, count drop pulses
  task automatic monitor();
    exp_t e;
    if (rst_n && key_valid && key_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event_code", int'(key_value), -1);
      end else begin
        e = exp_q.pop_front();
        chk("event_code", int'(key_value), e.code);
        chk("event_cycle", cyc, e.cyc);
      end
    end
    if (rst_n && overflow) ov_cnt++;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Press key k for 10 cycles; event must be visible exactly 7 edges after the press
  task automatic press_check(input int k, input int code);
    int c;
    c = cyc;
    key_raw[k] = 1'b1;
    exp_q.push_back('{code, c + 7});
    steps(7);
    chk("key_held_on", int'(key_held), 1);
    steps(3);
    key_raw[k] = 1'b0;
    steps(12);
    chk("key_held_off", int'(key_held), 0);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic tap(input int k);
    key_raw[k] = 1'b1;
    steps(6);
    key_raw[k] = 1'b0;
    steps(10);
  endtask

  initial begin
    int c, r, ov0;
    vecs = '{'{0, 1}, '{1, 2}, '{2, 3}, '{3, 4}, '{4, 5}, '{5, 6},
             '{6, 7}, '{7, 8}, '{8, 9}, '{9, 10}, '{10, 0}, '{11, 11}};

    // Reset state
    steps(3);
    chk("rst_key_valid", int'(key_valid), 0);
    chk("rst_key_value", int'(key_value), 0);
    chk("rst_key_held",  int'(key_held), 0);
    chk("rst_overflow",  int'(overflow), 0);
    rst_n = 1'b1;
    steps(2);

    // Every key once: code map and press latency
    for (int i = 0; i < 12; i++) press_check(vecs[i].key, vecs[i].code);

    // 3-cycle glitch: rejected
    key_raw[0] = 1'b1;
    steps(3);
    key_raw[0] = 1'b0;
    steps(12);
    chk("glitch_key_held", int'(key_held), 0);
    chk("glitch_key_valid", int'(key_valid), 0);

    // 4-cycle pulse: just long enough to be accepted
    c = cyc;
    key_raw[0] = 1'b1;
    exp_q.push_back('{1, c + 7});
    steps(4);
    key_raw[0] = 1'b0;
    steps(14);
    chk("min_pulse_drained", exp_q.size(), 0);

    // Chord while held: one event, then lockout until all released
    c = cyc;
    key_raw[2] = 1'b1;
    exp_q.push_back('{3, c + 7});
    steps(10);
    chk("chord_first_held", int'(key_held), 1);
    key_raw[11] = 1'b1;
    steps(10);
    chk("chord_lock_held", int'(key_held), 0);
    key_raw[2] = 1'b0;
    steps(10);
    chk("chord_lock_after_first_release", int'(key_held), 0);
    key_raw[11] = 1'b0;
    steps(10);
    chk("chord_drained", exp_q.size(), 0);
    press_check(11, 11);

    // Two keys together from idle: no event at all
    key_raw[3] = 1'b1;
    key_raw[4] = 1'b1;
    steps(10);
    chk("idle_chord_held", int'(key_held), 0);
    key_raw[3] = 1'b0;
    key_raw[4] = 1'b0;
    steps(12);

    // Auto-repeat: offsets 0, 20, 28, 36, 44 after acceptance, stop on release
    c = cyc;
    key_raw[9] = 1'b1;
    exp_q.push_back('{10, c + 7});
    exp_q.push_back('{10, c + 27});
    exp_q.push_back('{10, c + 35});
    exp_q.push_back('{10, c + 43});
    exp_q.push_back('{10, c + 51});
    steps(51);
    key_raw[9] = 1'b0;
    steps(15);
    chk("repeat_drained", exp_q.size(), 0);
    chk("repeat_held_off", int'(key_held), 0);

    // Back-pressure: 4 queued, 5th dropped with one overflow pulse, then drain
    key_ready = 1'b0;
    ov0 = ov_cnt;
    for (int k = 0; k < 5; k++) tap(k);
    chk("overflow_pulses", ov_cnt - ov0, 1);
    chk("head_valid", int'(key_valid), 1);
    chk("head_value_held", int'(key_value), 1);
    r = cyc;
    for (int k = 0; k < 4; k++) exp_q.push_back('{k + 1, r + k});
    key_ready = 1'b1;
    steps(6);
    chk("overflow_drained", exp_q.size(), 0);
    chk("overflow_valid_off", int'(key_valid), 0);

    // Reset mid-operation with events queued and a key held
    key_ready = 1'b0;
    tap(0);
    tap(1);
    key_raw[4] = 1'b1;
    steps(10);
    chk("pre_reset_held", int'(key_held), 1);
    chk("pre_reset_valid", int'(key_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_key_valid", int'(key_valid), 0);
    chk("mid_rst_key_value", int'(key_value), 0);
    chk("mid_rst_key_held",  int'(key_held), 0);
    chk("mid_rst_overflow",  int'(overflow), 0);
    exp_q.delete();
    steps(2);
    key_ready = 1'b1;
    rst_n = 1'b1;
    c = cyc;
    exp_q.push_back('{5, c + 7});
    steps(10);
    key_raw[4] = 1'b0;
    steps(12);
    chk("post_reset_drained", exp_q.size(), 0);
    chk("post_reset_held_off", int'(key_held), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_keypad_db.md
# button_keypad_db

Parametrised successor of the 12-button keypad front end. It takes `NUM_KEYS` raw active-high button levels and synchronises and debounces each key. It applies single-key press rules with chord lockout, optional auto-repeat, and a per-key code map, then queues key codes in a small FIFO with a valid/ready handshake to the lock-control FSM. Default parameters reproduce the existing 4×3 code convention (0–9 digits, `*`=10, `#`=11).

## Interface
Parameters:
- `NUM_KEYS`, 12: number of raw key inputs.
- `CODE_W`, 4: width of emitted key code.
- `KEYMAP`, {11,0,10,9,8,7,6,5,4,3,2,1}: packed `NUM_KEYS*CODE_W` vector; slice i is the code for `key_raw[i]`. The default maps index 0..8→1..9, 9→10 (`*`), 10→0, 11→11 (`#`).
- `DEBOUNCE_CYCLES`, 250000: consecutive stable cycles required to accept a level change; must be ≥1.
- `REPEAT_EN`, 0: 1 enables auto-repeat.
- `REPEAT_DELAY`, 25000000: cycles from first event to first repeat.
- `REPEAT_RATE`, 5000000: cycles between subsequent repeats.
- `FIFO_DEPTH`, 4: event queue depth; power of two, ≥2.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `key_raw` in `NUM_KEYS`: raw button levels, asynchronous, active-high.
- `key_ready` in 1: consumer accepts the head event.
- `key_valid` out 1: head event present.
- `key_value` out `CODE_W`: code of the head event; held stable while `key_valid && !key_ready`.
- `key_held` out 1: exactly one debounced key is currently pressed.
- `overflow` out 1: one-cycle pulse when an event is dropped because the FIFO is full.

## Operation
- Per key: a 2-FF synchroniser, then a debounce counter. The debounced level `db[i]` toggles when the synchronised level has differed from `db[i]` for `DEBOUNCE_CYCLES` consecutive cycles. Any agreeing sample clears the counter.
- The press FSM runs on the `db` vector and has four states:
  - IDLE: `db`==0. If one bit rises while all others are 0, emit `KEYMAP[i]`, latch i, and go to HELD. If two or more bits are set, go to LOCK with no event.
  - HELD: the latched key is down. If any other key rises, go to LOCK with no further events. If the latched key falls and `db`==0, go to IDLE. With `REPEAT_EN`=1, when the repeat counter reaches `REPEAT_DELAY`, emit again and go to REPEAT.
  - REPEAT: emit `KEYMAP[i]` every `REPEAT_RATE` cycles. Release and chord transitions are the same as in HELD.
  - LOCK: no events. Return to IDLE only when `db`==0.
- `key_held` = 1 in HELD and REPEAT, 0 otherwise.
- FIFO:
  - A write occurs on each emitted event.
  - A read occurs on `key_valid && key_ready`.
  - Write when full: the new event is dropped, the queue is unchanged, and `overflow` pulses.
  - Simultaneous read and write when full: both succeed, with no overflow.
  - Simultaneous read and write when empty: the write is stored and no read occurs. The FIFO is not bypassed.
- Pointer width is log2(`FIFO_DEPTH`)+1. Pointers wrap naturally; full and empty are decoded from the MSB.

## Timing
- Reset values (asynchronous, on `rst_n`=0):
  - Outputs: `key_valid`=0, `key_value`=0, `key_held`=0, `overflow`=0.
  - Internal: synchronisers, `db`, and counters are 0; FSM is in IDLE; FIFO is empty.
- Reset asserted mid-operation discards queued events. After release, a key that is still held is seen as a fresh press once debounced.
- Press latency, with the FIFO empty: `key_valid` rises `DEBOUNCE_CYCLES`+3 rising edges after the first edge that samples `key_raw[i]`=1. The breakdown is:
  - 2 edges for the synchroniser;
  - `DEBOUNCE_CYCLES`−1 edges of counting plus 1 edge to update `db`;
  - 1 edge for the FSM/FIFO write.
- `key_value` is valid in the same cycle as `key_valid`.
- Handshake: an event is consumed on the edge where `key_valid && key_ready`. The next event, if queued, is presented in the following cycle, so back-to-back reads are allowed.
- The repeat counter starts at 0 on the edge of the first emission:
  - first repeat is emitted `REPEAT_DELAY` cycles later;
  - subsequent repeats are emitted every `REPEAT_RATE` cycles.
- Glitches shorter than `DEBOUNCE_CYCLES` produce no `db` change and no event.

## Structure
- A shared package (`keypad_pkg`) holds:
  - code constants `KEY_STAR`=10 and `KEY_HASH`=11;
  - the default 12-key `KEYMAP`;
  - the FSM state encoding (IDLE, HELD, REPEAT, LOCK).
- Sub-module `key_debounce`: one instance per key via generate. It contains the synchroniser and debounce counter and outputs `db`.
- The FSM, repeat counter, and FIFO live in the top level.

## Test plan
Simulations use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_RATE`=8, `FIFO_DEPTH`=4, and `key_ready`=1 unless stated.
- Single press of `key_raw[10]` held for 10 cycles → one event with `key_value`=0, `key_valid` rising exactly 7 edges after the press; `key_held` is 1 until debounced release.
- 3-cycle glitch on `key_raw[0]` → no event; `db` stays 0.
- `key_raw[2]` pressed, then `key_raw[11]` pressed while held → one event with code 3 only; LOCK holds until both keys are released; a following `key_raw[11]` press → code 11.
- `REPEAT_EN`=1, `key_raw[9]` held for 50 cycles after acceptance → code 10 emitted at offsets 0, 20, 28, 36, and 44, then stops on release.
- `key_ready`=0 with 5 distinct presses → first 4 codes queued in order (1, 2, 3, 4); `overflow` pulses once on the 5th; raising `key_ready` drains 1, 2, 3, 4 on consecutive cycles.
- `rst_n` pulled low with 2 events queued and key 5 held → all outputs 0 immediately; after release, key 5 is re-debounced and emits code 5 once.
